// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: 2-flop sync, 3-sample majority vote, N/P/S framing, error flags, show-ahead output FIFO.
// Word reaches tvalid one cycle after the final stop-bit mid-sample; a full FIFO with tready low drops the word and pulses overrun.
module uart_rx_ext #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int N_BITS     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data,
  output logic [N_BITS-1:0] uart_rx_tdata,
  output logic [1:0]        uart_rx_tuser,
  output logic              uart_rx_tvalid,
  input  logic              uart_rx_tready,
  output logic              rx_busy,
  output logic              overrun
);

  localparam int N_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int HALF    = N_TICKS / 2;
  localparam int CW      = $clog2(N_TICKS + 1);
  localparam int BW      = $clog2(N_BITS + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CNTW    = PW + 1;
  localparam int EW      = N_BITS + 2;

  localparam logic [CW-1:0]   T_S0     = CW'(HALF - 1);
  localparam logic [CW-1:0]   T_S1     = CW'(HALF);
  localparam logic [CW-1:0]   T_MID    = CW'(HALF + 1);
  localparam logic [CW-1:0]   T_END    = CW'(N_TICKS - 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(N_BITS - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);
  localparam logic            PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rx_meta;
  logic              r_rx_s;
  logic [CW-1:0]     r_tick;
  logic [BW-1:0]     r_bit;
  logic              r_stop;
  logic              r_smp0;
  logic              r_smp1;
  logic [N_BITS-1:0] r_shift;
  logic              r_perr;
  logic              r_ferr;

  logic              w_mid;
  logic              w_end;
  logic              w_vote;
  logic              w_last_stop;
  logic              w_ferr_now;
  logic              w_push;
  logic [EW-1:0]     w_push_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_data;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_mid       = (r_tick == T_MID);
  assign w_end       = (r_tick == T_END);
  // Third sample is the live synchronised value at tick HALF+1.
  assign w_vote      = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);
  assign w_last_stop = (STOP_BITS == 1) || r_stop;
  assign w_ferr_now  = r_ferr | ~w_vote;
  assign w_push_dat  = {w_ferr_now, r_perr, r_shift};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE:      if (!r_rx_s) w_state_nxt = S_START;
      S_START: begin
        if (w_mid && w_vote) w_state_nxt = S_IDLE;
        else if (w_end)      w_state_nxt = S_DATA;
      end
      S_DATA:      if (w_end && (r_bit == LAST_BIT)) w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (w_end) w_state_nxt = S_STOP;
      S_STOP: begin
        // Leave at the mid-sample so a slightly fast sender's next start edge is not missed.
        if (w_mid && w_last_stop) begin
          w_push      = 1'b1;
          w_state_nxt = w_ferr_now ? S_WAIT_HIGH : S_IDLE;
        end
      end
      S_WAIT_HIGH: if (r_rx_s) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_smp0  <= 1'b1;
      r_smp1  <= 1'b1;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else if (r_state == S_IDLE || r_state == S_WAIT_HIGH) begin
      r_tick <= '0;
      r_bit  <= '0;
      r_stop <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_tick <= w_end ? '0 : r_tick + 1'b1;
      if (r_tick == T_S0) r_smp0 <= r_rx_s;
      if (r_tick == T_S1) r_smp1 <= r_rx_s;
      if (w_mid) begin
        case (r_state)
          S_DATA:   r_shift <= {w_vote, r_shift[N_BITS-1:1]};
          S_PARITY: r_perr  <= ((^r_shift) ^ w_vote) != PAR_ODD;
          S_STOP:   r_ferr  <= w_ferr_now;
          default:  ;
        endcase
      end
      if (w_end) begin
        if (r_state == S_DATA) r_bit  <= r_bit + 1'b1;
        if (r_state == S_STOP) r_stop <= 1'b1;
      end
    end
  end

  assign rx_busy = (r_state != S_IDLE) && (r_state != S_WAIT_HIGH);

  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CNTW-1:0] r_count;
  logic            r_overrun;
  logic            w_full;
  logic            w_pop;
  logic            w_wr_en;
  logic [EW-1:0]   w_head;

  assign uart_rx_tvalid = (r_count != '0);
  assign w_full         = (r_count == FULL_CNT);
  assign w_pop          = uart_rx_tvalid & uart_rx_tready;
  assign w_wr_en        = w_push & (~w_full | w_pop);
  assign w_head         = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= w_push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_pop)   r_rd <= r_rd + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overrun <= w_push & w_full & ~w_pop;
    end
  end

  // Memory is not reset, so the head is masked until it holds a real word.
  assign uart_rx_tdata = uart_rx_tvalid ? w_head[N_BITS-1:0] : '0;
  assign uart_rx_tuser = uart_rx_tvalid ? w_head[EW-1:N_BITS] : 2'b00;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: an 8N1 instance (a) and a 7E1 instance (b), both at 16 clocks per bit.
module tb_uart_rx_ext;

  localparam int NT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       tready_a = 1'b1;
  logic       tready_b = 1'b1;
  logic [7:0] tdata_a;
  logic [1:0] tuser_a;
  logic       tvalid_a, busy_a, ovr_a;
  logic [6:0] tdata_b;
  logic [1:0] tuser_b;
  logic       tvalid_b, busy_b, ovr_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ovr_a  = 0;
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  uart_rx_ext #(.CLK_FREQ(1_843_200), .BAUD_RATE(115200), .N_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_a),
    .uart_rx_tdata(tdata_a), .uart_rx_tuser(tuser_a), .uart_rx_tvalid(tvalid_a),
    .uart_rx_tready(tready_a), .rx_busy(busy_a), .overrun(ovr_a));

  uart_rx_ext #(.CLK_FREQ(1_843_200), .BAUD_RATE(115200), .N_BITS(7), .PARITY(2),
                .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_b),
    .uart_rx_tdata(tdata_b), .uart_rx_tuser(tuser_b), .uart_rx_tvalid(tvalid_b),
    .uart_rx_tready(tready_b), .rx_busy(busy_b), .overrun(ovr_b));

  always #5 clk = ~clk;

  // Beats are collected on the falling edge; tready only changes just after a rising edge.
  always @(negedge clk) begin
    if (tvalid_a && tready_a) q_a.push_back({6'd0, tuser_a, tdata_a});
    if (tvalid_b && tready_b) q_b.push_back({7'd0, tuser_b, tdata_b});
    if (ovr_a) n_ovr_a++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rx_b = b;
    else     rx_a = b;
  endtask

  task automatic send_bit(input bit sel, input logic b);
    drive(sel, b);
    repeat (NT) @(negedge clk);
  endtask

  // One-cycle inverted pulse at the bit centre; two of the three votes still see b.
  task automatic send_glitch_bit(input bit sel, input logic b);
    drive(sel, b);
    repeat (8) @(negedge clk);
    drive(sel, ~b);
    @(negedge clk);
    drive(sel, b);
    repeat (NT - 9) @(negedge clk);
  endtask

  task automatic send_word(input bit sel, input logic [8:0] d, input int nb);
    send_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) send_bit(sel, d[i]);
  endtask

  task automatic expect_beat(input bit sel, input string tag, input logic [15:0] exp);
    logic [15:0] got;
    got = 16'hFFFF;
    if (sel) begin
      if (q_b.size() > 0) got = q_b.pop_front();
    end else begin
      if (q_a.size() > 0) got = q_a.pop_front();
    end
    chk(tag, got, exp);
  endtask

  task automatic expect_none(input bit sel, input string tag);
    chk(tag, sel ? 16'(q_b.size()) : 16'(q_a.size()), 16'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out_a", 16'({tvalid_a, tuser_a, tdata_a, busy_a, ovr_a}), 16'd0);
    chk("reset_out_b", 16'({tvalid_b, tuser_b, tdata_b, busy_b, ovr_b}), 16'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Back-to-back 8N1 frames.
    send_word(1'b0, 9'h055, 8);
    chk("busy_in_frame", 16'(busy_a), 16'd1);
    send_bit(1'b0, 1'b1);
    chk("busy_after_stop", 16'(busy_a), 16'd0);
    send_word(1'b0, 9'h0A3, 8);
    send_bit(1'b0, 1'b1);
    expect_beat(1'b0, "beat_55", 16'h0055);
    expect_beat(1'b0, "beat_A3", 16'h00A3);
    expect_none(1'b0, "no_extra_beat_t1");

    // 7E1 parity checking.
    send_word(1'b1, 9'h041, 7);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    expect_beat(1'b1, "par_bad_41", 16'h00C1);
    send_word(1'b1, 9'h041, 7);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    expect_beat(1'b1, "par_ok_41", 16'h0041);
    send_word(1'b1, 9'h007, 7);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    expect_beat(1'b1, "par_bad_07", 16'h0087);

    // Framing error with the line held low (break).
    send_word(1'b0, 9'h05A, 8);
    repeat (3) send_bit(1'b0, 1'b0);
    chk("busy_in_wait_high", 16'(busy_a), 16'd0);
    expect_beat(1'b0, "frame_err_5A", 16'h025A);
    repeat (2) send_bit(1'b0, 1'b1);
    expect_none(1'b0, "no_beat_after_break");
    send_word(1'b0, 9'h07E, 8);
    send_bit(1'b0, 1'b1);
    expect_beat(1'b0, "beat_7E", 16'h007E);

    // Short glitch on an idle line is rejected.
    rx_a = 1'b0;
    repeat (2) @(negedge clk);
    rx_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_high", 16'(busy_a), 16'd1);
    repeat (10) @(negedge clk);
    chk("glitch_busy_low", 16'(busy_a), 16'd0);
    repeat (NT) @(negedge clk);
    expect_none(1'b0, "glitch_no_beat");

    // Mid-bit glitches inside 0xF0 are voted out.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 1 || i == 4 || i == 6) send_glitch_bit(1'b0, (i >= 4));
      else                            send_bit(1'b0, (i >= 4));
    end
    send_bit(1'b0, 1'b1);
    expect_beat(1'b0, "vote_F0", 16'h00F0);

    // FIFO fill, overrun on the fifth word, then drain.
    @(posedge clk);
    #1 tready_a = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      send_word(1'b0, 9'(k), 8);
      send_bit(1'b0, 1'b1);
    end
    chk("no_overrun_at_full", 16'(n_ovr_a), 16'd0);
    send_word(1'b0, 9'h005, 8);
    send_bit(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("overrun_once", 16'(n_ovr_a), 16'd1);
    chk("stalled_head", 16'({tvalid_a, tuser_a, tdata_a}), 16'h0401);
    expect_none(1'b0, "no_beat_while_stalled");
    @(posedge clk);
    #1 tready_a = 1'b1;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 4; k++) expect_beat(1'b0, "drain", 16'(k));
    expect_none(1'b0, "drain_only_four");
    chk("tvalid_after_drain", 16'(tvalid_a), 16'd0);

    // Reset in the middle of 0xC3's data bits.
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    rst  = 1'b1;
    rx_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midframe_reset_out", 16'({tvalid_a, tuser_a, tdata_a, busy_a, ovr_a}), 16'd0);
    repeat (2 * NT) @(negedge clk);
    expect_none(1'b0, "no_beat_aborted_frame");
    send_word(1'b0, 9'h03C, 8);
    send_bit(1'b0, 1'b1);
    expect_beat(1'b0, "beat_3C", 16'h003C);
    chk("busy_idle_end", 16'(busy_a), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
